// File: rtl/parking_display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// parking_display_scan_ctrl
//
// Purpose:
//   Time-multiplexes NUM_DIGITS per-zone free-space counts (0..4) onto one
//   shared BCD-to-7-segment decoder. Every digit slot is SCAN_DIV cycles long:
//   one dark BLANK cycle (dead time, so the previous digit never ghosts onto
//   the next one) followed by SCAN_DIV-1 SHOW cycles. The count of a zone is
//   captured once on SHOW entry so a digit never changes mid-slot.
//
// Ports:
//   clk          in   1             system clock, rising edge
//   rst          in   1             synchronous, active-high reset
//   enable       in   1             1 = scan the display, 0 = display dark
//   counts       in   3*NUM_DIGITS  zone i free count at counts[3*i+2:3*i]
//   seg_code     out  3             decoder binary input, 3'b111 = blank
//   digit_en     out  NUM_DIGITS    one-hot digit select, all-0 = none lit
//   frame_start  out  1             pulse on the first SHOW cycle of digit 0
//   range_err    out  1             sticky flag, illegal count (5..7) seen
//
// Parameters:
//   NUM_DIGITS   number of zones/digits, 2..8
//   SCAN_DIV     clk cycles per digit slot, >= 2
//   BLINK_DIV    frames per blink half-period, >= 1 (blink build only)
//
// Build option:
//   BLINK_FULL_EN  when defined, a zone showing 0 (full) blinks: in the off
//                  phase its slot shows blank while digit_en stays asserted.
//                  When undefined, 0 is always shown as 3'b000.
// ---------------------------------------------------------------------------
module parking_display_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [3*NUM_DIGITS-1:0] counts,
  output logic [2:0]              seg_code,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_start,
  output logic                    range_err
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(SCAN_DIV);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  localparam logic [PW-1:0] PRESC_TC = PW'(SCAN_DIV - 2);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [2:0]    SEG_BLANK = 3'b111;

  // Elaboration-time guard on the legal parameter ranges.
  if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("NUM_DIGITS must be in 2..8");
  end
  if (SCAN_DIV < 2) begin : g_bad_div
    $error("SCAN_DIV must be >= 2");
  end
  if (BLINK_DIV < 1) begin : g_bad_blink
    $error("BLINK_DIV must be >= 1");
  end

  // Decoder code for a captured count: illegal values and blink-off zeros
  // both map to the decoder's blank code.
  function automatic logic [2:0] seg_sel(input logic [2:0] snap,
                                         input logic       hide_zero);
    if (snap > 3'd4)
      return SEG_BLANK;
    else if (hide_zero && (snap == 3'd0))
      return SEG_BLANK;
    else
      return snap;
  endfunction

  logic [1:0]            state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [2:0]            snap_q, snap_d;
  logic [2:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] den_q, den_d;
  logic                  fs_q, fs_d;
  logic                  rerr_q, rerr_d;

  logic [2:0]            cur_slice;
  logic                  show_entry;
  logic                  frame_wrap;
  logic                  hide_zero;

  // Count slice of the digit addressed by the current index.
  always_comb begin
    cur_slice = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) cur_slice = counts[3*i +: 3];
    end
  end

  // Scan FSM: IDLE -> BLANK -> SHOW -> BLANK ... ; enable low always
  // returns to IDLE with the index and prescaler cleared, so a re-enable
  // restarts cleanly at digit 0 via a BLANK cycle.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    presc_d    = presc_q;
    snap_d     = snap_q;
    show_entry = 1'b0;
    frame_wrap = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      presc_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          idx_d   = '0;
          presc_d = '0;
        end
        ST_BLANK: begin
          state_d    = ST_SHOW;
          presc_d    = '0;
          snap_d     = cur_slice;
          show_entry = 1'b1;
        end
        ST_SHOW: begin
          if (presc_q == PRESC_TC) begin
            state_d = ST_BLANK;
            presc_d = '0;
            if (idx_q == IDX_LAST) begin
              idx_d      = '0;
              frame_wrap = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          presc_d = '0;
        end
      endcase
    end
  end

`ifdef BLINK_FULL_EN
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_DIV - 1);

  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          phase_on_q, phase_on_d;

  // Frames are counted at each index wrap; the very first frame after
  // reset/re-enable starts from IDLE, so it is frame 0 with the on phase.
  // The phase only changes at BLANK entry, so it is stable for every SHOW.
  always_comb begin
    fcnt_d     = fcnt_q;
    phase_on_d = phase_on_q;
    if (state_d == ST_IDLE) begin
      fcnt_d     = '0;
      phase_on_d = 1'b1;
    end else if (frame_wrap) begin
      if (fcnt_q == FCNT_LAST) begin
        fcnt_d     = '0;
        phase_on_d = ~phase_on_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q     <= '0;
      phase_on_q <= 1'b1;
    end else begin
      fcnt_q     <= fcnt_d;
      phase_on_q <= phase_on_d;
    end
  end

  assign hide_zero = ~phase_on_d;
`else
  assign hide_zero = 1'b0;
`endif

  // Output next-state: outputs are registered alongside the FSM so they
  // reflect the state being entered on this edge.
  always_comb begin
    den_d  = '0;
    seg_d  = SEG_BLANK;
    fs_d   = 1'b0;
    rerr_d = rerr_q;
    if (state_d == ST_SHOW) begin
      den_d = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_d;
      seg_d = seg_sel(snap_d, hide_zero);
    end
    if (show_entry) begin
      fs_d = (idx_d == '0);
      if (cur_slice > 3'd4) rerr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      presc_q <= '0;
      seg_q   <= SEG_BLANK;
      den_q   <= '0;
      fs_q    <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      presc_q <= presc_d;
      seg_q   <= seg_d;
      den_q   <= den_d;
      fs_q    <= fs_d;
      rerr_q  <= rerr_d;
    end
  end

  // The snapshot is pure data; it is always rewritten before it is shown.
  always_ff @(posedge clk) begin
    snap_q <= snap_d;
  end

  assign seg_code    = seg_q;
  assign digit_en    = den_q;
  assign frame_start = fs_q;
  assign range_err   = rerr_q;

endmodule
